// File: rtl/key_cond_pkg.sv
// Shared constants for the push-button conditioner: state encoding and default timing.
// The optional auto-repeat behaviour in key_conditioner is enabled by defining KEY_AUTOREPEAT_EN.
package key_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } key_state_t;

  localparam int unsigned DEF_DEB_CYCLES = 500000;
  localparam int unsigned DEF_REP_DELAY  = 25000000;
  localparam int unsigned DEF_REP_PERIOD = 5000000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_conditioner_sync_2ff.sv
// Two-flop synchronizer for the raw active-low button; resets to 1 so the key reads as released.
module sync_2ff (
  input  logic clock_i,
  input  logic areset_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_conditioner.sv
// Debounces a push-button into a one-cycle press pulse and a pressed level.
// Define KEY_AUTOREPEAT_EN to add hold-to-repeat pulses (REP_DELAY first, then every REP_PERIOD).
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned REP_DELAY  = DEF_REP_DELAY,
  parameter int unsigned REP_PERIOD = DEF_REP_PERIOD,
  localparam int CNT_W  = $clog2(DEB_CYCLES),
  localparam int RCNT_W = $clog2(max_u(REP_DELAY, REP_PERIOD))
) (
  input  logic              clock,
  input  logic              areset_n,
  input  logic              key_n,
  output logic              key_pulse,
  output logic              key_level,
  output key_state_t        dbg_state,
  output logic [CNT_W-1:0]  dbg_cnt,
  output logic [RCNT_W-1:0] dbg_rcnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [RCNT_W-1:0] REP_FIRST_LAST = RCNT_W'(REP_DELAY - 1);
  localparam logic [RCNT_W-1:0] REP_NEXT_LAST  = RCNT_W'(REP_PERIOD - 1);
  logic rep_first_q;
`endif

  key_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [RCNT_W-1:0] rcnt_q;
  logic              pulse_q;
  logic              level_q;
  logic              key_n_sync;
  logic              key_sync;

  sync_2ff u_sync (
    .clock_i    (clock),
    .areset_n_i (areset_n),
    .d_i        (key_n),
    .q_o        (key_n_sync)
  );

  assign key_sync = ~key_n_sync;

  // Debounce counters stop at CNT_LAST because the state always changes there.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= RELEASED;
      cnt_q       <= '0;
      rcnt_q      <= '0;
      pulse_q     <= 1'b0;
      level_q     <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rep_first_q <= 1'b1;
`endif
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        RELEASED: begin
          if (key_sync) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!key_sync) begin
            state_q <= RELEASED;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= PRESSED;
            pulse_q     <= 1'b1;
            level_q     <= 1'b1;
            rcnt_q      <= '0;
`ifdef KEY_AUTOREPEAT_EN
            rep_first_q <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!key_sync) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
`ifdef KEY_AUTOREPEAT_EN
          else if (rcnt_q == (rep_first_q ? REP_FIRST_LAST : REP_NEXT_LAST)) begin
            pulse_q     <= 1'b1;
            rcnt_q      <= '0;
            rep_first_q <= 1'b0;
          end else begin
            rcnt_q <= rcnt_q + RCNT_W'(1);
          end
`endif
        end
        RELEASE_WAIT: begin
          if (key_sync) begin
            // Bounce on release: back to held, repeat timing starts over.
            state_q     <= PRESSED;
            rcnt_q      <= '0;
`ifdef KEY_AUTOREPEAT_EN
            rep_first_q <= 1'b1;
`endif
          end else if (cnt_q == CNT_LAST) begin
            state_q <= RELEASED;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= RELEASED;
      endcase
    end
  end

  assign key_pulse = pulse_q;
  assign key_level = level_q;
  assign dbg_state = state_q;
  assign dbg_cnt   = cnt_q;
  assign dbg_rcnt  = rcnt_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with DEB_CYCLES=4, REP_DELAY=8, REP_PERIOD=4.
// Repeat expectations follow KEY_AUTOREPEAT_EN when it is defined for the build.
module tb_key_conditioner;
  import key_cond_pkg::*;

  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 8;
  localparam int unsigned RP  = 4;

  typedef struct {
    logic key_n;
    logic exp_pulse;
    logic exp_level;
  } vec_t;

  logic       clock    = 1'b0;
  logic       areset_n = 1'b0;
  logic       key_n    = 1'b1;
  logic       key_pulse;
  logic       key_level;
  key_state_t dbg_state;
  logic [1:0] dbg_cnt;
  logic [2:0] dbg_rcnt;

  int         checks = 0;
  int         errors = 0;
  int         exp_presses = 0;
  logic       pulse_prev = 1'b0;
  logic [7:0] updown_count = '0;
  vec_t       vecs[$];

  // Clock / reset
  always #5 clock = ~clock;

  key_conditioner #(
    .DEB_CYCLES (DEB),
    .REP_DELAY  (RD),
    .REP_PERIOD (RP)
  ) dut (
    .clock     (clock),
    .areset_n  (areset_n),
    .key_n     (key_n),
    .key_pulse (key_pulse),
    .key_level (key_level),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt),
    .dbg_rcnt  (dbg_rcnt)
  );

  // Downstream up/down counter, Key2 = key_pulse, counting up.
  always @(posedge clock) begin
    if (key_pulse) updown_count <= updown_count + 8'd1;
  end

  always @(negedge clock) begin
    if (key_pulse) begin
      checks++;
      if (pulse_prev) begin
        errors++;
        $display("FAIL pulse_back_to_back: got two consecutive pulses, required one-cycle pulse");
      end
    end
    pulse_prev = key_pulse;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Driver: set key away from the edge, then sample 1ns after the rising edge.
  task automatic step(input logic k);
    key_n = k;
    @(posedge clock);
    #1;
  endtask

  function automatic void add(input logic k, input logic p, input logic l, input int n);
    for (int i = 0; i < n; i++) vecs.push_back('{k, p, l});
  endfunction

  function automatic logic rep_expected(input int k);
`ifdef KEY_AUTOREPEAT_EN
    return (k >= int'(RD)) && (((k - int'(RD)) % int'(RP)) == 0);
`else
    return (k < 0);
`endif
  endfunction

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation did not complete within the time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int first_t;

    // Reset state, asserted at time 0 with no clock edge yet
    #1;
    check("reset_pulse", key_pulse, 0);
    check("reset_level", key_level, 0);
    check("reset_state", dbg_state, RELEASED);
    check("reset_cnt", dbg_cnt, 0);
    check("reset_rcnt", dbg_rcnt, 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    areset_n = 1'b1;

    // Clean press (pulse at edge 7), release bounce, full release
    add(0, 0, 0, 6); add(0, 1, 1, 1); add(0, 0, 1, 2);
    add(1, 0, 1, 2); add(0, 0, 1, 5);
    add(1, 0, 1, 6); add(1, 0, 0, 1); add(1, 0, 0, 2);
    // Press bounce: low 3, high 1, low held -> pulse 7 edges after final fall
    add(0, 0, 0, 3); add(1, 0, 0, 1); add(0, 0, 0, 6); add(0, 1, 1, 1); add(0, 0, 1, 1);
    add(1, 0, 1, 6); add(1, 0, 0, 1); add(1, 0, 0, 2);
    exp_presses += 2;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].key_n);
      check($sformatf("vec%0d_pulse", i), key_pulse, vecs[i].exp_pulse);
      check($sformatf("vec%0d_level", i), key_level, vecs[i].exp_level);
    end
    check("idle_state", dbg_state, RELEASED);

    // Hold for auto-repeat
    first_t = -1;
    for (int t = 1; t <= 20 && first_t < 0; t++) begin
      step(0);
      if (key_pulse) first_t = t;
    end
    check("hold_first_latency", first_t, 7);
    exp_presses += 1;
    for (int k = 1; k <= 30; k++) begin
      step(0);
      check($sformatf("hold_t%0d_pulse", k), key_pulse, rep_expected(k));
      if (rep_expected(k)) exp_presses += 1;
    end
    for (int k = 0; k < 7; k++) step(1);
    check("hold_release_level", key_level, 0);
    step(1);

    // Reset mid-PRESS_WAIT with key still held
    for (int k = 0; k < 5; k++) step(0);
    check("rst_pw_state", dbg_state, PRESS_WAIT);
    check("rst_pw_cnt", dbg_cnt, 2);
    areset_n = 1'b0;
    #1;
    check("rst_pw_async_state", dbg_state, RELEASED);
    check("rst_pw_async_cnt", dbg_cnt, 0);
    check("rst_pw_async_pulse", key_pulse, 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    check("rst_pw_hold_pulse", key_pulse, 0);
    areset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(0);
      check($sformatf("rst_pw_wait%0d_pulse", k), key_pulse, 0);
    end
    step(0);
    check("rst_pw_after_pulse", key_pulse, 1);
    check("rst_pw_after_level", key_level, 1);
    exp_presses += 1;

    // Reset while pressed: level drops at once, held key re-debounced
    step(0);
    areset_n = 1'b0;
    #1;
    check("rst_pr_async_level", key_level, 0);
    check("rst_pr_async_state", dbg_state, RELEASED);
    @(posedge clock);
    @(posedge clock);
    #1;
    areset_n = 1'b1;
    for (int k = 0; k < 6; k++) step(0);
    check("rst_pr_early_pulse", key_pulse, 0);
    step(0);
    check("rst_pr_after_pulse", key_pulse, 1);
    exp_presses += 1;
    for (int k = 0; k < 8; k++) step(1);
    check("rst_pr_release_level", key_level, 0);
    check("rst_pr_release_state", dbg_state, RELEASED);

    // Integration: downstream counter moved once per accepted pulse
    step(1);
    check("updown_count", updown_count, exp_presses);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 500000, the number of stable clock cycles required to accept a press or a release (minimum 2).
REQ-002 SHALL have parameter REP_DELAY, default 25000000, the cycles from the first pulse to the first auto-repeat pulse (minimum 2).
REQ-003 SHALL have parameter REP_PERIOD, default 5000000, the cycles between subsequent auto-repeat pulses (minimum 2).
REQ-004 SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port areset_n, input, 1 bit, an asynchronous active-low reset.
REQ-006 SHALL have port key_n, input, 1 bit, a raw asynchronous push-button (0 = pressed).
REQ-007 SHALL have port key_pulse, output, 1 bit, a registered one-cycle pulse per accepted press, used as the Key2 input of the downstream up/down counter.
REQ-008 SHALL have port key_level, output, 1 bit, a registered debounced "pressed" level.

Function
REQ-009 SHALL pass key_n through a two-flop synchronizer; key_sync SHALL be the inverted second-flop output (1 = pressed).
REQ-010 SHALL implement four states: RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-011 In RELEASED with key_sync=1, SHALL go to PRESS_WAIT and clear the debounce counter cnt; otherwise SHALL stay in RELEASED.
REQ-012 In PRESS_WAIT with key_sync=0, SHALL return to RELEASED (bounce rejected); otherwise SHALL increment cnt.
REQ-013 In PRESS_WAIT, when cnt==DEB_CYCLES-1 and key_sync=1, SHALL go to PRESSED, set key_pulse=1 for exactly one cycle and clear the repeat counter rcnt.
REQ-014 Press latency: with key_n first sampled low at rising edge 1 and held low, key_pulse SHALL be high during the clock period following edge DEB_CYCLES+3.
REQ-015 In PRESSED with key_sync=0, SHALL go to RELEASE_WAIT and clear cnt.
REQ-016 In RELEASE_WAIT with key_sync=1, SHALL return to PRESSED with no pulse.
REQ-017 In RELEASE_WAIT, cnt SHALL increment, and when cnt==DEB_CYCLES-1 with key_sync=0 the block SHALL go to RELEASED.
REQ-018 key_level SHALL be 1 exactly when the state is PRESSED or RELEASE_WAIT.
REQ-019 key_pulse SHALL never be high on two consecutive cycles.
REQ-020 key_pulse SHALL never be high outside the entry into PRESSED or an auto-repeat event.
REQ-021 cnt SHALL be $clog2(DEB_CYCLES) bits wide and SHALL never wrap.
REQ-022 rcnt SHALL be wide enough for the larger of REP_DELAY and REP_PERIOD.

Reset
REQ-023 While areset_n=0, all of the following SHALL hold immediately, independent of clock: state=RELEASED, cnt=0, rcnt=0, key_pulse=0, key_level=0, and both synchronizer flops=1 (released).
REQ-024 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no pulse.
REQ-025 A key held through reset release SHALL be debounced afresh and produce one pulse per REQ-014.

Configuration
REQ-026 With KEY_AUTOREPEAT_EN defined, in PRESSED with key_sync=1, rcnt SHALL increment each cycle.
REQ-027 With KEY_AUTOREPEAT_EN defined, repeat pulses SHALL occur REP_DELAY cycles after the initial pulse and then every REP_PERIOD cycles while held.
REQ-028 With KEY_AUTOREPEAT_EN defined, entering RELEASE_WAIT SHALL stop repeats, and returning to PRESSED SHALL restart the timing from REP_DELAY.
REQ-029 Without KEY_AUTOREPEAT_EN, rcnt and the REP_* parameters SHALL have no effect and exactly one pulse SHALL occur per accepted press.

Structure
REQ-030 Package key_cond_pkg SHALL hold the state encoding constants (RELEASED=2'b00, PRESS_WAIT=2'b01, PRESSED=2'b10, RELEASE_WAIT=2'b11) and the default DEB/REP values.
REQ-031 The synchronizer SHALL be the sub-module sync_2ff, reset value 1.

Verification
All scenarios use DEB_CYCLES=4, REP_DELAY=8, REP_PERIOD=4.
REQ-032 Clean press: key_n low from edge 1 -> exactly one key_pulse after edge 7; key_level rises with it.
REQ-033 Bounce: key_n low for 3 cycles, then high for 1, then low and held -> no pulse until 7 edges after the final fall.
REQ-034 Release bounce: pressed, then key_n high for 2 cycles and low again -> key_level stays 1 and no second pulse; a release held for 7 edges -> key_level=0.
REQ-035 Auto-repeat (macro on): hold for 30 cycles after the first pulse at cycle T -> pulses at T, T+8, T+12, T+16, T+20, T+24, T+28; with the macro off, only the pulse at T.
REQ-036 Reset mid-PRESS_WAIT: areset_n low for 2 cycles at cnt=2 -> outputs go to 0 immediately, no pulse; key still held -> pulse 7 edges after reset release.
REQ-037 Integration: drive the downstream counter's Key2 with key_pulse -> each press moves count by exactly 1.
